// File: rtl/key_event_detect.sv
// key_event_detect
//   Classifies presses of one debounced, active-low key as short, double or
//   long and emits one-cycle event pulses to the application logic. While a
//   long press is held, auto-repeat pulses can optionally be emitted.
//
//   Optional feature macro: KEY_REPEAT_EN
//     defined   : repeat_pulse fires every REPEAT_CNT cycles while a long
//                 press is held
//     undefined : repeat_pulse is tied to 0, LONG_HOLD just waits for release
//
//   Ports
//     clk          in   system clock
//     rst_n        in   asynchronous reset, active-low
//     key_jit      in   debounced key level, 0 = pressed, synchronous to clk
//     short_pulse  out  one-cycle pulse, single short press completed
//     double_pulse out  one-cycle pulse, second press of a double click
//     long_pulse   out  one-cycle pulse, long-press threshold reached
//     repeat_pulse out  one-cycle auto-repeat pulse
//     busy         out  high whenever the FSM is not in IDLE
//
//   All timing is in clk cycles; the defaults assume a 12 MHz clk.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | key released, no press in progress
//   PRESS1    | first press held, timing towards the long threshold
//   GAP       | first press released, waiting for a second press
//   LONG_HOLD | long press declared, waiting for release (and repeating)
//   DBL_HOLD  | second press of a double click held, waiting for release

module key_event_detect #(
  parameter int                CNT_W       = 24,
  parameter logic [CNT_W-1:0]  LONG_CNT    = 24'd12_000_000,
  parameter logic [CNT_W-1:0]  DBL_GAP_CNT = 24'd3_600_000,
  parameter logic [CNT_W-1:0]  REPEAT_CNT  = 24'd2_400_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_jit,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  // Every count is compared against its last cycle, so a count below 2
  // would make the threshold coincide with the state-entry cycle.
  if ((LONG_CNT < CNT_W'(2)) || (DBL_GAP_CNT < CNT_W'(2)) ||
      (REPEAT_CNT < CNT_W'(2))) begin : g_bad_count
    $error("key_event_detect: LONG_CNT, DBL_GAP_CNT and REPEAT_CNT must be >= 2");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CNT - 1'b1;
  localparam logic [CNT_W-1:0] GAP_LAST  = DBL_GAP_CNT - 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    LONG_HOLD = 3'd3,
    DBL_HOLD  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             key_d;
  logic             fall;
  logic             rise;

  // key_d resets to 1 (released), so a key still held when reset is
  // released shows up as a fresh press on the first clock.
  assign fall = key_d & ~key_jit;
  assign rise = ~key_d & key_jit;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CNT - 1'b1;
  logic repeat_q;
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      key_d        <= 1'b1;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      busy         <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_q     <= 1'b0;
`endif
    end else begin
      key_d        <= key_jit;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_q     <= 1'b0;
`endif

      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state <= PRESS1;
            busy  <= 1'b1;
          end
        end

        // A release on the threshold cycle takes priority over long_pulse.
        PRESS1: begin
          if (rise) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG_HOLD;
            cnt        <= '0;
            long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A second press on the timeout cycle still counts as a double.
        GAP: begin
          if (fall) begin
            state        <= DBL_HOLD;
            cnt          <= '0;
            double_pulse <= 1'b1;
          end else if (cnt == GAP_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            short_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        LONG_HOLD: begin
          if (rise) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
`ifdef KEY_REPEAT_EN
          end else if (cnt == REPEAT_LAST) begin
            cnt      <= '0;
            repeat_q <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DBL_HOLD: begin
          cnt <= '0;
          if (rise) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_detect.sv
// Testbench for key_event_detect (LONG_CNT=20, DBL_GAP_CNT=8, REPEAT_CNT=5).
// Stimulus is a list of (level, length) key segments; the reference model
// walks the segment list and derives the cycle of every expected event from
// press/release durations alone.
module tb_key_event_detect;

  localparam int LONG = 20;
  localparam int GAP  = 8;
  localparam int REP  = 5;
  localparam int MAXC = 1024;

  localparam int EV_NONE  = 0;
  localparam int EV_SHORT = 1;
  localparam int EV_DBL   = 2;
  localparam int EV_LONG  = 3;
  localparam int EV_REP   = 4;

  logic clk;
  logic rst_n;
  logic key_jit;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic busy;

  int vectors     = 0;
  int miscompares = 0;

  int seg_lvl[$];
  int seg_len[$];
  int exp_ev[MAXC];
  bit exp_busy[MAXC];
  bit key_at[MAXC];

  key_event_detect #(
    .CNT_W      (24),
    .LONG_CNT   (24'd20),
    .DBL_GAP_CNT(24'd8),
    .REPEAT_CNT (24'd5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_jit     (key_jit),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic add_seg(input int lvl, input int len);
    seg_lvl.push_back(lvl);
    seg_len.push_back(len);
  endtask

  task automatic check(input string tag, input int n, input logic [4:0] exp_v);
    logic [4:0] obs;
    obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, busy};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: {short,double,long,repeat,busy} observed %b expected %b",
             tag, n, obs, exp_v);
    end
  endtask

  // phase: 0 = nothing pending, 1 = short press awaiting its release,
  //        2 = released inside the double-click window
  task automatic build_model(output int total);
    int s;
    int phase;
    total = 0;
    foreach (seg_len[i]) total += seg_len[i];
    if (total > MAXC) begin
      $display("FAIL model: segment list of %0d cycles exceeds %0d", total, MAXC);
      $fatal(1, "stimulus too long");
    end
    for (int n = 0; n < total; n++) begin
      exp_ev[n]   = EV_NONE;
      exp_busy[n] = 1'b0;
    end
    s     = 0;
    phase = 0;
    for (int i = 0; i < seg_lvl.size(); i++) begin
      int len;
      len = seg_len[i];
      for (int k = 0; k < len; k++) key_at[s+k] = (seg_lvl[i] != 0);
      if (seg_lvl[i] == 0) begin
        for (int k = 0; k < len; k++) exp_busy[s+k] = 1'b1;
        if (phase == 2) begin
          exp_ev[s] = EV_DBL;
          phase = 0;
        end else if (len > LONG) begin
          exp_ev[s+LONG] = EV_LONG;
`ifdef KEY_REPEAT_EN
          for (int k = 1; LONG + k*REP < len; k++) exp_ev[s+LONG+k*REP] = EV_REP;
`endif
          phase = 0;
        end else begin
          phase = 1;
        end
      end else if (phase == 1) begin
        if (len > GAP) begin
          for (int k = 0; k < GAP; k++) exp_busy[s+k] = 1'b1;
          exp_ev[s+GAP] = EV_SHORT;
          phase = 0;
        end else begin
          for (int k = 0; k < len; k++) exp_busy[s+k] = 1'b1;
          phase = 2;
        end
      end
      s += len;
    end
  endtask

  // Called at a falling clock edge; cycle n is the n-th rising edge after it.
  task automatic apply(input string tag);
    int total;
    logic [4:0] e;
    build_model(total);
    for (int n = 0; n < total; n++) begin
      key_jit = key_at[n];
      @(posedge clk);
      @(negedge clk);
      e = {exp_ev[n] == EV_SHORT, exp_ev[n] == EV_DBL, exp_ev[n] == EV_LONG,
           exp_ev[n] == EV_REP, exp_busy[n]};
      check(tag, n, e);
    end
    seg_lvl.delete();
    seg_len.delete();
  endtask

  task automatic do_reset(input logic lvl, input string tag);
    @(negedge clk);
    rst_n   = 1'b0;
    key_jit = lvl;
    #1;
    check({tag, "_async"}, 0, 5'b0);
    repeat (2) @(negedge clk);
    check(tag, 2, 5'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    key_jit = 1'b1;

    do_reset(1'b1, "reset_idle");

    add_seg(1, 3); add_seg(0, 5); add_seg(1, 12);
    apply("short");

    add_seg(0, 3); add_seg(1, 4); add_seg(0, 30); add_seg(1, 12);
    apply("double");

    add_seg(0, 32); add_seg(1, 12);
    apply("long_hold");

    add_seg(0, LONG); add_seg(1, 12);
    apply("release_on_long_threshold");

    add_seg(0, 3); add_seg(1, GAP); add_seg(0, 4); add_seg(1, 12);
    apply("fall_on_gap_timeout");

    add_seg(0, 30); add_seg(1, 12);
    apply("release_on_repeat_cycle");

    add_seg(0, 10);
    apply("press_before_reset");
    do_reset(1'b0, "reset_key_held");
    add_seg(0, 32); add_seg(1, 12);
    apply("held_through_reset");

    for (int it = 0; it < 25; it++) begin
      add_seg(1, $urandom_range(1, 4));
      for (int p = 0; p < 5; p++) begin
        add_seg(0, $urandom_range(1, LONG + 12));
        add_seg(1, $urandom_range(1, GAP + 3));
      end
      add_seg(0, $urandom_range(1, LONG + 12));
      add_seg(1, GAP + 4);
      apply("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
